// File: rtl/fp_addsub_unit_if.sv
// Request/response bundle for fp_addsub_unit: operands and control in, result and status out.
interface fp_addsub_unit_if;
    logic        start;
    logic [4:0]  fmt;
    logic        sub;
    logic [63:0] FPOperandA;
    logic [63:0] FPOperandB;
    logic        busy;
    logic        done;
    logic [63:0] FPResult;

    modport master (output start, fmt, sub, FPOperandA, FPOperandB,
                    input  busy, done, FPResult);
    modport slave  (input  start, fmt, sub, FPOperandA, FPOperandB,
                    output busy, done, FPResult);
endinterface

// File: rtl/fp_addsub_unit.sv
// Multi-cycle IEEE-754 single/double adder-subtractor: truncating rounding, denormals flushed,
// one FSM stage per clock (UNPACK, ALIGN, ADD, NORM, PACK).
module fp_addsub_unit (
    input  logic             clk,
    input  logic             rst_n,
    fp_addsub_unit_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, PACK} state_t;

    state_t       state_reg;
    logic         busy_reg, done_reg;
    logic [63:0]  result_reg;

    logic [4:0]   fmt_reg;
    logic         sub_reg;
    logic [63:0]  a_reg, b_reg;

    logic         dbl_reg, special_reg;
    logic [63:0]  special_val_reg;
    logic         sign_a_reg, sign_b_reg;
    logic [10:0]  exp_a_reg, exp_b_reg;
    logic [52:0]  man_a_reg, man_b_reg;

    logic         sign_big_reg, sign_small_reg;
    logic [10:0]  exp_big_reg;
    logic [55:0]  man_big_reg, man_small_reg;

    logic         sign_res_reg;
    logic [56:0]  sum_reg;

    logic signed [12:0] exp_norm_reg;
    logic [55:0]  man_norm_reg;
    logic         zero_reg;

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.FPResult = result_reg;

    // ---------------- unpack (from latched operands) ----------------
    logic              is_single, is_double;
    logic [10:0]       emax;
    logic [1:0]        s_u, zero_u, inf_u, nan_u;
    logic [1:0][10:0]  e_u;
    logic [1:0][51:0]  f_u;
    logic [1:0][52:0]  m_u;

    assign is_single = (fmt_reg == 5'h10);
    assign is_double = (fmt_reg == 5'h11);
    assign emax      = is_double ? 11'h7FF : 11'h0FF;

    // Single fractions are left-justified so both formats share one datapath.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            logic [63:0] opv;
            assign opv        = (gi == 0) ? a_reg : b_reg;
            assign s_u[gi]    = is_double ? opv[63] : opv[31];
            assign e_u[gi]    = is_double ? opv[62:52] : {3'b0, opv[30:23]};
            assign f_u[gi]    = is_double ? opv[51:0] : {opv[22:0], 29'b0};
            assign zero_u[gi] = (e_u[gi] == 11'd0);
            assign inf_u[gi]  = (e_u[gi] == emax) && (f_u[gi] == 52'd0);
            assign nan_u[gi]  = (e_u[gi] == emax) && (f_u[gi] != 52'd0);
            assign m_u[gi]    = zero_u[gi] ? 53'd0 : {1'b1, f_u[gi]};
        end
    endgenerate

    logic        sb_eff;
    logic        special_c;
    logic [63:0] special_val_c, qnan_c;

    assign sb_eff = s_u[1] ^ sub_reg;
    assign qnan_c = is_double ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;

    always_comb begin
        special_c     = 1'b1;
        special_val_c = 64'd0;
        if (!(is_single || is_double)) begin
            special_val_c = 64'd0;
        end else if (nan_u[0] || nan_u[1] || (inf_u[0] && inf_u[1] && (s_u[0] != sb_eff))) begin
            special_val_c = qnan_c;
        end else if (inf_u[0]) begin
            special_val_c = is_double ? {s_u[0], 11'h7FF, 52'd0} : {32'd0, s_u[0], 8'hFF, 23'd0};
        end else if (inf_u[1]) begin
            special_val_c = is_double ? {sb_eff, 11'h7FF, 52'd0} : {32'd0, sb_eff, 8'hFF, 23'd0};
        end else begin
            special_c = 1'b0;
        end
    end

    // ---------------- align ----------------
    logic        a_ge;
    logic [10:0] exp_diff;
    logic [52:0] man_small_c;
    logic [55:0] shifted_c;

    assign a_ge        = {exp_a_reg, man_a_reg} >= {exp_b_reg, man_b_reg};
    assign exp_diff    = a_ge ? (exp_a_reg - exp_b_reg) : (exp_b_reg - exp_a_reg);
    assign man_small_c = a_ge ? man_b_reg : man_a_reg;
    assign shifted_c   = (exp_diff >= 11'd56) ? 56'd0 : ({man_small_c, 3'b000} >> exp_diff);

    // ---------------- normalize ----------------
    logic [5:0]         lz;
    logic               lz_found;
    logic signed [12:0] exp_big_s;

    always_comb begin
        lz       = 6'd56;
        lz_found = 1'b0;
        for (int i = 55; i >= 0; i--) begin
            if (!lz_found && sum_reg[i]) begin
                lz       = 6'(55 - i);
                lz_found = 1'b1;
            end
        end
    end

    assign exp_big_s = $signed({2'b00, exp_big_reg});

    // ---------------- pack ----------------
    logic signed [12:0] emax_s;
    logic [63:0]        pack_c;

    assign emax_s = dbl_reg ? 13'sd2047 : 13'sd255;

    always_comb begin
        pack_c = 64'd0;
        if (special_reg) begin
            pack_c = special_val_reg;
        end else if (zero_reg) begin
            pack_c = 64'd0;
        end else if (exp_norm_reg <= 13'sd0) begin
            pack_c = dbl_reg ? {sign_res_reg, 63'd0} : {32'd0, sign_res_reg, 31'd0};
        end else if (exp_norm_reg >= emax_s) begin
            pack_c = dbl_reg ? {sign_res_reg, 11'h7FF, 52'd0} : {32'd0, sign_res_reg, 8'hFF, 23'd0};
        end else if (dbl_reg) begin
            pack_c = {sign_res_reg, exp_norm_reg[10:0], man_norm_reg[54:3]};
        end else begin
            pack_c = {32'd0, sign_res_reg, exp_norm_reg[7:0], man_norm_reg[54:32]};
        end
    end

    // ---------------- FSM and pipeline registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            result_reg      <= 64'd0;
            fmt_reg         <= 5'd0;
            sub_reg         <= 1'b0;
            a_reg           <= 64'd0;
            b_reg           <= 64'd0;
            dbl_reg         <= 1'b0;
            special_reg     <= 1'b0;
            special_val_reg <= 64'd0;
            sign_a_reg      <= 1'b0;
            sign_b_reg      <= 1'b0;
            exp_a_reg       <= 11'd0;
            exp_b_reg       <= 11'd0;
            man_a_reg       <= 53'd0;
            man_b_reg       <= 53'd0;
            sign_big_reg    <= 1'b0;
            sign_small_reg  <= 1'b0;
            exp_big_reg     <= 11'd0;
            man_big_reg     <= 56'd0;
            man_small_reg   <= 56'd0;
            sign_res_reg    <= 1'b0;
            sum_reg         <= 57'd0;
            exp_norm_reg    <= 13'sd0;
            man_norm_reg    <= 56'd0;
            zero_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        fmt_reg   <= bus.fmt;
                        sub_reg   <= bus.sub;
                        a_reg     <= bus.FPOperandA;
                        b_reg     <= bus.FPOperandB;
                        busy_reg  <= 1'b1;
                        state_reg <= UNPACK;
                    end
                end
                UNPACK: begin
                    dbl_reg         <= is_double;
                    special_reg     <= special_c;
                    special_val_reg <= special_val_c;
                    sign_a_reg      <= s_u[0];
                    sign_b_reg      <= sb_eff;
                    exp_a_reg       <= e_u[0];
                    exp_b_reg       <= e_u[1];
                    man_a_reg       <= m_u[0];
                    man_b_reg       <= m_u[1];
                    state_reg       <= ALIGN;
                end
                ALIGN: begin
                    sign_big_reg   <= a_ge ? sign_a_reg : sign_b_reg;
                    sign_small_reg <= a_ge ? sign_b_reg : sign_a_reg;
                    exp_big_reg    <= a_ge ? exp_a_reg : exp_b_reg;
                    man_big_reg    <= {(a_ge ? man_a_reg : man_b_reg), 3'b000};
                    man_small_reg  <= shifted_c;
                    state_reg      <= ADD;
                end
                ADD: begin
                    sum_reg      <= (sign_big_reg == sign_small_reg)
                                    ? ({1'b0, man_big_reg} + {1'b0, man_small_reg})
                                    : ({1'b0, man_big_reg} - {1'b0, man_small_reg});
                    sign_res_reg <= sign_big_reg;
                    state_reg    <= NORM;
                end
                NORM: begin
                    zero_reg     <= (sum_reg == 57'd0);
                    man_norm_reg <= sum_reg[56] ? sum_reg[56:1] : (sum_reg[55:0] << lz);
                    exp_norm_reg <= sum_reg[56] ? (exp_big_s + 13'sd1)
                                                : (exp_big_s - $signed({7'd0, lz}));
                    state_reg    <= PACK;
                end
                PACK: begin
                    result_reg <= pack_c;
                    done_reg   <= 1'b1;
                    // A start already waiting as the result retires is taken at once,
                    // so a held start yields one result every five cycles.
                    if (bus.start) begin
                        fmt_reg   <= bus.fmt;
                        sub_reg   <= bus.sub;
                        a_reg     <= bus.FPOperandA;
                        b_reg     <= bus.FPOperandB;
                        state_reg <= UNPACK;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_unit.sv
// Directed bench for fp_addsub_unit: vector table for arithmetic, hand sequences for control.
module tb_fp_addsub_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;

    fp_addsub_unit_if bus ();

    fp_addsub_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  fmt;
        logic        sub;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] expect_res;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    // Drive a one-cycle start, then watch 12 edges; returns first done edge, done count, result.
    task automatic run_op(input logic [4:0] f, input logic s, input logic [63:0] a,
                          input logic [63:0] b, output int lat, output int ndone,
                          output logic [63:0] res);
        @(negedge clk);
        bus.fmt = f; bus.sub = s; bus.FPOperandA = a; bus.FPOperandB = b; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0; ndone = 0; res = 64'hx;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                if (lat == 0) begin
                    lat = e;
                    res = bus.FPResult;
                end
            end
        end
    endtask

    initial begin
        int lat, ndone, e_first, e_second;
        logic [63:0] res, res2;

        vecs[0]  = '{"s_add_1p2",     5'h10, 1'b0, 64'h3F800000, 64'h40000000, 64'h40400000};
        vecs[1]  = '{"s_sub_neg",     5'h10, 1'b1, 64'h40400000, 64'h40A00000, 64'hC0000000};
        vecs[2]  = '{"d_cancel",      5'h11, 1'b1, 64'h3FF8000000000000, 64'h3FF8000000000000, 64'h0};
        vecs[3]  = '{"s_truncate",    5'h10, 1'b0, 64'h3F800000, 64'h30800000, 64'h3F800000};
        vecs[4]  = '{"s_inf_m_inf",   5'h10, 1'b1, 64'h7F800000, 64'h7F800000, 64'h7FC00000};
        vecs[5]  = '{"s_overflow",    5'h10, 1'b0, 64'h7F7FFFFF, 64'h7F7FFFFF, 64'h7F800000};
        vecs[6]  = '{"d_add_1p2",     5'h11, 1'b0, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000};
        vecs[7]  = '{"s_nan_in",      5'h10, 1'b0, 64'h7FC00001, 64'h3F800000, 64'h7FC00000};
        vecs[8]  = '{"s_ninf_p_fin",  5'h10, 1'b0, 64'hFF800000, 64'h3F800000, 64'hFF800000};
        vecs[9]  = '{"bad_fmt",       5'h00, 1'b0, 64'h3F800000, 64'h40000000, 64'h0};
        vecs[10] = '{"s_denorm_flush",5'h10, 1'b0, 64'h00000001, 64'h3F800000, 64'h3F800000};
        vecs[11] = '{"s_underflow",   5'h10, 1'b1, 64'h00800000, 64'h00C00000, 64'h80000000};
        vecs[12] = '{"d_sub_neg",     5'h11, 1'b1, 64'h3FF0000000000000, 64'h3FF8000000000000, 64'hBFE0000000000000};
        vecs[13] = '{"s_zero_nzero",  5'h10, 1'b0, 64'h00000000, 64'h80000000, 64'h0};
        vecs[14] = '{"d_inf_m_inf",   5'h11, 1'b1, 64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000};
        vecs[15] = '{"s_one_m_one",   5'h10, 1'b1, 64'h3F800000, 64'h3F800000, 64'h0};

        bus.start = 1'b0; bus.fmt = 5'h10; bus.sub = 1'b0;
        bus.FPOperandA = 64'd0; bus.FPOperandB = 64'd0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",   {63'd0, bus.busy}, 64'd0);
        check("reset_done",   {63'd0, bus.done}, 64'd0);
        check("reset_result", bus.FPResult, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // first start right after reset release is taken on the next edge
        @(negedge clk);
        bus.fmt = 5'h10; bus.sub = 1'b0; bus.FPOperandA = 64'h3F800000; bus.FPOperandB = 64'h40000000;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("post_reset_accept", {63'd0, bus.busy}, 64'd1);
        repeat (8) @(posedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].fmt, vecs[i].sub, vecs[i].a, vecs[i].b, lat, ndone, res);
            $display("[TB] %s: a=%h b=%h sub=%0d -> %h (latency %0d, dones %0d)",
                     vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sub, res, lat, ndone);
            check({vecs[i].name, "_result"}, res, vecs[i].expect_res);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'd5);
            check({vecs[i].name, "_ndone"}, 64'(ndone), 64'd1);
        end

        // result holds after done
        #1 check("result_hold", bus.FPResult, 64'h0);
        check("idle_busy", {63'd0, bus.busy}, 64'd0);

        // start pulsed at k+2 is ignored and the latched operands stay intact
        @(negedge clk);
        bus.fmt = 5'h10; bus.sub = 1'b0; bus.FPOperandA = 64'h3F800000; bus.FPOperandB = 64'h40000000;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        ndone = 0; lat = 0; res = 64'hx;
        for (int e = 1; e <= 14; e++) begin
            if (e == 2) begin
                bus.start = 1'b1; bus.sub = 1'b1;
                bus.FPOperandA = 64'h40400000; bus.FPOperandB = 64'h40A00000;
            end
            @(posedge clk);
            #1 bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                if (lat == 0) begin lat = e; res = bus.FPResult; end
            end
        end
        $display("[TB] ignored_start: result %h latency %0d dones %0d", res, lat, ndone);
        check("ignored_start_ndone", 64'(ndone), 64'd1);
        check("ignored_start_result", res, 64'h40400000);
        check("ignored_start_latency", 64'(lat), 64'd5);

        // reset asserted mid-operation at k+3
        @(negedge clk);
        bus.fmt = 5'h10; bus.sub = 1'b1; bus.FPOperandA = 64'h40400000; bus.FPOperandB = 64'h40A00000;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_busy",   {63'd0, bus.busy}, 64'd0);
        check("midreset_result", bus.FPResult, 64'd0);
        check("midreset_done",   {63'd0, bus.done}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        ndone = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1 if (bus.done) ndone++;
        end
        $display("[TB] mid_reset: busy %0d result %h dones after %0d", bus.busy, bus.FPResult, ndone);
        check("midreset_no_done", 64'(ndone), 64'd0);

        // start held through done: back-to-back, second result at k+10
        @(negedge clk);
        bus.fmt = 5'h10; bus.sub = 1'b0; bus.FPOperandA = 64'h3F800000; bus.FPOperandB = 64'h40000000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.sub = 1'b1; bus.FPOperandA = 64'h40400000; bus.FPOperandB = 64'h40A00000;
        e_first = 0; e_second = 0; res = 64'hx; res2 = 64'hx;
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk);
            #1;
            if (e == 5) bus.start = 1'b0;
            if (bus.done) begin
                if (e_first == 0) begin e_first = e; res = bus.FPResult; end
                else if (e_second == 0) begin e_second = e; res2 = bus.FPResult; end
            end
        end
        $display("[TB] back_to_back: first %h at k+%0d, second %h at k+%0d", res, e_first, res2, e_second);
        check("b2b_first_edge",    64'(e_first), 64'd5);
        check("b2b_first_result",  res, 64'h40400000);
        check("b2b_second_edge",   64'(e_second), 64'd10);
        check("b2b_second_result", res2, 64'hC0000000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fp_addsub_unit.md
FP_ADDSUB_UNIT -- requirements
Module: fp_addsub_unit

Interface
REQ-001 One clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 fmt  input  5  operand format: 5'h10 single, 5'h11 double.
REQ-006 sub  input  1  0 = A+B, 1 = A-B.
REQ-007 FPOperandA  input  64  first operand; single uses [31:0].
REQ-008 FPOperandB  input  64  second operand; single uses [31:0].
REQ-009 busy  output  1  operation in progress; the pipeline stalls while high.
REQ-010 done  output  1  one-cycle pulse: FPResult valid.
REQ-011 FPResult  output  64  result; single places the result in [31:0] and 32'b0 in [63:32].

Function
REQ-012 FSM states: IDLE, UNPACK, ALIGN, ADD, NORM, PACK.
REQ-013 IDLE with start=1 at edge k: latch fmt, sub and both operands, then go to UNPACK and set busy=1.
REQ-014 Transitions run one per edge: UNPACK->ALIGN->ADD->NORM->PACK->IDLE.
REQ-015 Latency: done=1 and FPResult is updated at edge k+5; busy falls at the same edge.
REQ-016 done is high for exactly one cycle.
REQ-017 FPResult holds its value until the next PACK or reset.
REQ-018 start is ignored while busy=1; the latched operands are not disturbed.
REQ-019 start=1 in the same cycle that done=1 is accepted, giving back-to-back operations.
REQ-020 UNPACK stage:
- Split sign, exponent (8/11 bits) and fraction (23/52 bits).
- Prepend hidden 1 to the fraction.
- Exponent 0 is treated as zero (denormals flushed).
- sub=1 inverts the sign of B.
REQ-021 ALIGN stage:
- Order the operands by magnitude.
- Right-shift the smaller mantissa by the exponent difference.
- Keep 3 guard bits; the shift saturates at mantissa width + 3.
REQ-022 ADD stage:
- Equal signs: add the mantissas.
- Unequal signs: subtract smaller from larger.
- The result takes the sign of the larger magnitude.
REQ-023 NORM stage, single-cycle:
- Carry out: shift right 1, exponent+1.
- Otherwise left-shift by the leading-zero count, exponent minus that count.
REQ-024 Rounding is truncation (round toward zero); guard bits are discarded.
REQ-025 Exact zero result: +0.
REQ-026 Exponent underflow (<=0): signed zero.
REQ-027 Exponent overflow (>=max): signed infinity.
REQ-028 Special operands, resolved in UNPACK and passed through to PACK:
- Any NaN: canonical NaN (single 32'h7FC00000, double 64'h7FF8000000000000).
- inf - inf (effective): canonical NaN.
- inf with finite: that infinity.
REQ-029 fmt other than 5'h10/5'h11: the operation still completes in 5 cycles with FPResult = 0.
REQ-030 All arithmetic uses latched values; input changes during busy have no effect.

Reset
REQ-031 rst_n=0 forces, at any time including mid-operation:
- state = IDLE
- busy = 0
- done = 0
- FPResult = 64'b0
REQ-032 After rst_n rises, the first start is accepted on the next rising edge.
REQ-033 An operation interrupted by reset produces no done pulse.

Verification
REQ-034 Single add: fmt=10h, A=3F800000, B=40000000, sub=0 -> done at k+5, FPResult=0000000040400000.
REQ-035 Single subtract, negative result: A=40400000, B=40A00000, sub=1 -> C0000000.
REQ-036 Double cancellation: fmt=11h, A=B=3FF8000000000000, sub=1 -> 0000000000000000.
REQ-037 Truncation: single A=3F800000, B=30800000 (2^-30) -> 3F800000.
REQ-038 Single special cases:
- A=B=7F800000, sub=1 -> 7FC00000.
- A=B=7F7FFFFF, sub=0 -> 7F800000.
REQ-039 Control cases:
- start pulsed at k+2 is ignored (one done only).
- rst_n low at k+3 -> busy=0, FPResult=0, no done.
- start held through done -> second result at k+10.
